// File: rtl/wb_mem_waitstate.sv
// Word-organised Wishbone data memory with byte selects, programmable wait
// states, error response for out-of-range addresses and an optional post-reset clear.
module wb_mem_waitstate #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_SIZE_KB    = 64,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned WAIT_STATES    = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    init_done_o
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(NUM_LANES);
  localparam int unsigned MEM_DEPTH = MEM_SIZE_KB * 1024 / NUM_LANES;
  localparam int unsigned WORD_AW   = $clog2(MEM_DEPTH);
  localparam int unsigned IDX_TOP   = LANE_BITS + WORD_AW;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_e                 state_q,     state_d;
  logic [2:0]             cnt_q,       cnt_d;
  logic [WORD_AW-1:0]     ptr_q,       ptr_d;
  logic [WORD_AW-1:0]     idx_q,       idx_d;
  logic                   oor_q,       oor_d;
  logic [DATA_WIDTH-1:0]  wdat_q,      wdat_d;
  logic [NUM_LANES-1:0]   sel_q,       sel_d;
  logic                   we_q,        we_d;
  logic                   ack_q,       ack_d;
  logic                   err_q,       err_d;
  logic [DATA_WIDTH-1:0]  rdat_q,      rdat_d;
  logic                   init_done_q, init_done_d;

  logic [WORD_AW-1:0]     idx_in;
  logic                   oor_in;
  logic                   unused_adr;

  logic [WORD_AW-1:0]     t_idx;
  logic                   t_oor;
  logic                   t_we;
  logic [DATA_WIDTH-1:0]  t_dat;
  logic [NUM_LANES-1:0]   t_sel;
  logic [DATA_WIDTH-1:0]  rd_word;

  logic                   commit;
  logic                   mem_we;
  logic [WORD_AW-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [NUM_LANES-1:0]   mem_be;

  always_comb begin
    idx_in     = wb_adr_i[LANE_BITS +: WORD_AW];
    oor_in     = |(wb_adr_i >> IDX_TOP);
    // Lane-offset bits never select anything; lanes come from wb_sel_i.
    unused_adr = ^wb_adr_i;
  end

  // With zero wait states the commit happens on the accepting edge, so the
  // live bus fields are used instead of the latched copies.
  always_comb begin
    if (state_q == S_IDLE) begin
      t_idx = idx_in;
      t_oor = oor_in;
      t_we  = wb_we_i;
      t_dat = wb_dat_i;
      t_sel = wb_sel_i;
    end else begin
      t_idx = idx_q;
      t_oor = oor_q;
      t_we  = we_q;
      t_dat = wdat_q;
      t_sel = sel_q;
    end
    rd_word = mem[t_idx];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    oor_d       = oor_q;
    wdat_d      = wdat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdat_d      = rdat_q;
    init_done_d = init_done_q | (state_q != S_CLEAR);
    commit      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = t_idx;
    mem_wdata   = t_dat;
    mem_be      = t_sel;

    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        mem_be    = '1;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == WORD_AW'(MEM_DEPTH - 1)) begin
          ptr_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i && init_done_q) begin
          idx_d  = idx_in;
          oor_d  = oor_in;
          wdat_d = wb_dat_i;
          sel_d  = wb_sel_i;
          we_d   = wb_we_i;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_RESP;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase

    if (commit) begin
      if (t_oor) begin
        err_d  = 1'b1;
        rdat_d = '0;
      end else begin
        ack_d  = 1'b1;
        mem_we = t_we;
        rdat_d = t_we ? '0 : rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      oor_q       <= 1'b0;
      wdat_q      <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdat_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      oor_q       <= oor_d;
      wdat_q      <= wdat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdat_q      <= rdat_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    wb_dat_o    = rdat_q;
    wb_ack_o    = ack_q;
    wb_err_o    = err_q;
    init_done_o = init_done_q;
  end

endmodule

// File: tb/tb_wb_mem_waitstate.sv
// Directed bench for wb_mem_waitstate: three instances cover clear/latency,
// byte lanes, error responses, abort and zero-wait back-to-back reads.
module tb_wb_mem_waitstate;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr   [3];
  logic [31:0] wdat  [3];
  logic [31:0] rdat  [3];
  logic [3:0]  sel   [3];
  logic        we    [3];
  logic        stb   [3];
  logic        cyc   [3];
  logic        ack   [3];
  logic        err   [3];
  logic        idone [3];

  int n_vec = 0;
  int n_bad = 0;

  // u0: 1 KB, two wait states, cleared after reset
  wb_mem_waitstate #(
    .DATA_WIDTH(32), .MEM_SIZE_KB(1), .ADDR_WIDTH(32), .WAIT_STATES(2), .CLEAR_ON_RESET(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_sel_i(sel[0]),
    .wb_we_i(we[0]), .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]), .wb_dat_o(rdat[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]), .init_done_o(idone[0])
  );

  // u1: 64 KB, three wait states, no clear
  wb_mem_waitstate #(
    .DATA_WIDTH(32), .MEM_SIZE_KB(64), .ADDR_WIDTH(32), .WAIT_STATES(3), .CLEAR_ON_RESET(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_sel_i(sel[1]),
    .wb_we_i(we[1]), .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]), .wb_dat_o(rdat[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]), .init_done_o(idone[1])
  );

  // u2: 1 KB, zero wait states, cleared after reset
  wb_mem_waitstate #(
    .DATA_WIDTH(32), .MEM_SIZE_KB(1), .ADDR_WIDTH(32), .WAIT_STATES(0), .CLEAR_ON_RESET(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[2]), .wb_dat_i(wdat[2]), .wb_sel_i(sel[2]),
    .wb_we_i(we[2]), .wb_stb_i(stb[2]), .wb_cyc_i(cyc[2]), .wb_dat_o(rdat[2]),
    .wb_ack_o(ack[2]), .wb_err_o(err[2]), .init_done_o(idone[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns after the response cycle plus one idle cycle.
  task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic w, input int max_cyc,
                      output int lat, output logic got_ack, output logic got_err,
                      output logic [31:0] got_dat);
    adr[d]  = a;
    wdat[d] = wd;
    sel[d]  = s;
    we[d]   = w;
    stb[d]  = 1'b1;
    cyc[d]  = 1'b1;
    lat     = 0;
    got_ack = 1'b0;
    got_err = 1'b0;
    got_dat = '0;
    while (lat < max_cyc && !got_ack && !got_err) begin
      @(negedge clk);
      lat++;
      got_ack = ack[d];
      got_err = err[d];
      got_dat = rdat[d];
    end
    stb[d] = 1'b0;
    cyc[d] = 1'b0;
    we[d]  = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_rd(input int d, input string tag, input logic [31:0] a,
                       input logic [31:0] exp_dat, input int exp_lat, input logic exp_err);
    int lat;
    logic ga, ge;
    logic [31:0] gd;
    xfer(d, a, 32'h0, 4'hF, 1'b0, 20, lat, ga, ge, gd);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_ack"}, {31'b0, ga}, {31'b0, ~exp_err});
    chk({tag, "_err"}, {31'b0, ge}, {31'b0, exp_err});
    chk({tag, "_dat"}, gd, exp_dat);
  endtask

  task automatic do_wr(input int d, input string tag, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] s,
                       input int exp_lat, input logic exp_err);
    int lat;
    logic ga, ge;
    logic [31:0] gd;
    xfer(d, a, wd, s, 1'b1, 20, lat, ga, ge, gd);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_ack"}, {31'b0, ga}, {31'b0, ~exp_err});
    chk({tag, "_err"}, {31'b0, ge}, {31'b0, exp_err});
    chk({tag, "_dat"}, gd, 32'h0);
  endtask

  initial begin
    int n_resp;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      adr[d] = '0; wdat[d] = '0; sel[d] = '0; we[d] = 1'b0; stb[d] = 1'b0; cyc[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_ack", d), {31'b0, ack[d]}, 32'h0);
      chk($sformatf("rst%0d_err", d), {31'b0, err[d]}, 32'h0);
      chk($sformatf("rst%0d_dat", d), rdat[d], 32'h0);
      chk($sformatf("rst%0d_init", d), {31'b0, idone[d]}, 32'h0);
    end

    rst_n = 1'b1;
    fork
      begin
        int n;
        n = 0;
        while (!idone[0] && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk("u0_init_lat", n, 257);
      end
      begin
        @(negedge clk);
        chk("u1_init_first_edge", {31'b0, idone[1]}, 32'h1);
      end
      begin
        int lat;
        logic ga, ge;
        logic [31:0] gd;
        // issued during the clear: held off until init_done, then served
        xfer(2, 32'h8, 32'h0, 4'hF, 1'b0, 400, lat, ga, ge, gd);
        chk("u2_stall_lat", lat, 258);
        chk("u2_stall_ack", {31'b0, ga}, 32'h1);
        chk("u2_stall_dat", gd, 32'h0);
      end
    join
    @(negedge clk);

    do_rd(0, "u0_rd3fc",  32'h3FC, 32'h0000_0000, 3, 1'b0);
    do_wr(0, "u0_wr10",   32'h10,  32'hDEAD_BEEF, 4'hF, 3, 1'b0);
    do_rd(0, "u0_rd10",   32'h10,  32'hDEAD_BEEF, 3, 1'b0);
    do_wr(0, "u0_wrpart", 32'h10,  32'h1122_3344, 4'b0101, 3, 1'b0);
    do_rd(0, "u0_rdpart", 32'h10,  32'hDE22_BE44, 3, 1'b0);
    chk("u0_dat_hold", rdat[0], 32'hDE22_BE44);
    do_rd(0, "u0_rd13",   32'h13,  32'hDE22_BE44, 3, 1'b0);
    do_wr(0, "u0_sel0",   32'h10,  32'hFFFF_FFFF, 4'h0, 3, 1'b0);
    do_rd(0, "u0_rdsel0", 32'h10,  32'hDE22_BE44, 3, 1'b0);
    do_rd(0, "u0_oor",    32'h400, 32'h0000_0000, 3, 1'b1);

    do_wr(1, "u1_wr4",    32'h4,       32'hCAFE_F00D, 4'hF, 4, 1'b0);
    do_rd(1, "u1_rd4",    32'h4,       32'hCAFE_F00D, 4, 1'b0);
    do_rd(1, "u1_oor_rd", 32'h0001_0000, 32'h0,       4, 1'b1);
    do_wr(1, "u1_oor_wr", 32'h0001_0004, 32'hFFFF_FFFF, 4'hF, 4, 1'b1);
    do_rd(1, "u1_rd4b",   32'h4,       32'hCAFE_F00D, 4, 1'b0);
    do_wr(1, "u1_wr20",   32'h20,      32'h1234_5678, 4'hF, 4, 1'b0);

    // drop cyc during the second wait cycle
    adr[1] = 32'h20; wdat[1] = 32'h55; sel[1] = 4'hF; we[1] = 1'b1;
    stb[1] = 1'b1; cyc[1] = 1'b1;
    n_resp = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_resp += int'(ack[1] | err[1]);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_resp += int'(ack[1] | err[1]);
    end
    chk("u1_abort_resp", n_resp, 0);
    do_rd(1, "u1_rd20",   32'h20,      32'h1234_5678, 4, 1'b0);

    do_wr(2, "u2_wr0", 32'h0, 32'hA5A5_0001, 4'hF, 1, 1'b0);
    do_wr(2, "u2_wr4", 32'h4, 32'h0BAD_F00D, 4'hF, 1, 1'b0);
    adr[2] = 32'h0; sel[2] = 4'hF; we[2] = 1'b0; stb[2] = 1'b1; cyc[2] = 1'b1;
    @(negedge clk);
    chk("u2_b2b_ack1", {31'b0, ack[2]}, 32'h1);
    chk("u2_b2b_dat1", rdat[2], 32'hA5A5_0001);
    adr[2] = 32'h4;
    @(negedge clk);
    chk("u2_b2b_gap",  {31'b0, ack[2]}, 32'h0);
    @(negedge clk);
    chk("u2_b2b_ack2", {31'b0, ack[2]}, 32'h1);
    chk("u2_b2b_dat2", rdat[2], 32'h0BAD_F00D);
    stb[2] = 1'b0; cyc[2] = 1'b0;
    @(negedge clk);
    chk("u2_b2b_end",  {31'b0, ack[2]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
